fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the core. It owns the PC register, issues sequential requests to a synchronous instruction memory with 1-cycle latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. The decode stage drains the FIFO through a valid/ready handshake. A branch redirect from execute flushes the queue and discards any in-flight response. This replaces the single-register PC/stall scheme of the previous core.

---
 rtl/fetch_queue_if.sv | 41 ++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 tb/tb_fetch_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory port, branch redirect and decode dequeue.
// Latency: none; this is wiring only.
// Backpressure: deq_ready stalls the decode side; the memory side has no stall.
interface fetch_queue_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               deq_valid;
  logic               deq_ready;
  logic [INSTR_W-1:0] deq_instr;
  logic [ADDR_W-1:0]  deq_pc;
  logic [CNT_W-1:0]   count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_data,
    input  redirect_valid, redirect_pc,
    output deq_valid,
    input  deq_ready,
    output deq_instr, deq_pc, count
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req, imem_addr,
    output imem_data,
    output redirect_valid, redirect_pc,
    input  deq_valid,
    output deq_ready,
    input  deq_instr, deq_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: PC register, sequential imem requests, DEPTH-entry {instr,pc} FIFO; FETCH_BYPASS_EN adds an empty-queue bypass.
// Latency: request to deq_valid is 2 cycles (1 cycle with FETCH_BYPASS_EN when the queue is empty); redirect to first entry is 3 (2).
// Backpressure: deq_ready=0 holds the head; requests stop once queued plus in-flight entries reach DEPTH.
module fetch_queue #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.master fq
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);
  localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               req;
  logic               fifo_vld;
  logic               byp_vld;
  logic               pop;
  logic               byp_take;
  logic               push;

  // Request gating, head/bypass selection and handshake decode
  always_comb begin
    occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
    // A same-cycle dequeue is deliberately not credited here; the FIFO can therefore never overflow.
    req       = reset && !fq.redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));
    fifo_vld  = (count_q != '0);
`ifdef FETCH_BYPASS_EN
    byp_vld   = !fifo_vld && inflight_q && !fq.redirect_valid;
`else
    byp_vld   = 1'b0;
`endif
    pop       = fifo_vld && fq.deq_ready;
    byp_take  = byp_vld && fq.deq_ready;
    // A bypassed response that decode accepts is never stored.
    push      = inflight_q && !fq.redirect_valid && !byp_take;

    fq.imem_req  = req;
    fq.imem_addr = pc_q;
    fq.deq_valid = fifo_vld || byp_vld;
    fq.deq_instr = byp_vld ? fq.imem_data : instr_mem[head_q];
    fq.deq_pc    = byp_vld ? req_pc_q     : pc_mem[head_q];
    fq.count     = count_q;
  end

  // Next-state: PC advance, in-flight tracking, pointer/count update, redirect flush
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = req;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;

    if (fq.redirect_valid) begin
      pc_d       = fq.redirect_pc & ALIGN_MASK;
      inflight_d = 1'b0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (req) begin
        pc_d     = pc_q + STEP;
        req_pc_d = pc_q;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset loses all queued and in-flight data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RST_PC;
      req_pc_q   <= RST_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= fq.imem_data;
      pc_mem[tail_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed timeline checks plus randomized traffic against a queue-based model.
// Latency: n/a.
// Backpressure: deq_ready and redirect are randomized.
module tb_fetch_queue;
  localparam int ADDR_W   = 16;
  localparam int INSTR_W  = 16;
  localparam int DEPTH    = 4;
  localparam int PC_STEP  = 4;
  localparam int RESET_PC = 0;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;

  fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) fq ();

  fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH),
    .PC_STEP(PC_STEP), .RESET_PC(RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a holds a>>2
  always @(posedge clk) fq.imem_data <= INSTR_W'(fq.imem_addr >> 2);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_pc;
  bit          m_inf;
  logic [15:0] m_inf_pc;

  bit          e_req, e_dv, e_byp;
  logic [15:0] e_pc, e_instr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a >> 2;
  endfunction

  function automatic void calc();
    e_req = reset && !fq.redirect_valid && ((mq.size() + int'(m_inf)) < DEPTH);
    e_byp = BYP && reset && (mq.size() == 0) && m_inf && !fq.redirect_valid;
    e_dv  = (mq.size() > 0) || e_byp;
    if (mq.size() > 0) begin
      e_pc = mq[0].pc;  e_instr = mq[0].instr;
    end else begin
      e_pc = m_inf_pc;  e_instr = mem_word(m_inf_pc);
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_pc     = 16'(RESET_PC);
      m_inf    = 1'b0;
      m_inf_pc = 16'(RESET_PC);
    end else begin
      calc();
      if (fq.redirect_valid) begin
        mq.delete();
        m_inf = 1'b0;
        m_pc  = fq.redirect_pc & ~16'(PC_STEP - 1);
      end else begin
        if (fq.deq_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_inf && !(e_byp && fq.deq_ready))
          mq.push_back('{pc: m_inf_pc, instr: mem_word(m_inf_pc)});
        m_inf = e_req;
        if (e_req) begin
          m_inf_pc = m_pc;
          m_pc     = m_pc + 16'(PC_STEP);
        end
      end
    end
  end

  logic [15:0] dut_log[$];

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    calc();
    cmp("imem_req", 32'(fq.imem_req), 32'(e_req));
    cmp("imem_addr", 32'(fq.imem_addr), 32'(m_pc));
    cmp("deq_valid", 32'(fq.deq_valid), 32'(e_dv));
    cmp("count", 32'(fq.count), 32'(mq.size()));
    cmp("count_le_depth", 32'(fq.count <= DEPTH), 32'd1);
    if (e_dv) begin
      cmp("deq_pc", 32'(fq.deq_pc), 32'(e_pc));
      cmp("deq_instr", 32'(fq.deq_instr), 32'(e_instr));
    end
    if (reset && fq.deq_valid && fq.deq_ready) dut_log.push_back(fq.deq_pc);
  end

  // ---------------- stimulus ----------------
  task automatic reset_pulse(input bit rdy);
    @(posedge clk); #1;
    reset = 1'b0;
    fq.deq_ready = rdy;
    fq.redirect_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_count(input int target, input string name);
    int i;
    for (i = 0; i < 30 && fq.count != target; i++) @(negedge clk);
    cmp(name, 32'(fq.count), 32'(target));
  endtask

  task automatic check_log(input string name, input logic [15:0] e0, e1, e2, e3);
    logic [15:0] exp[4];
    exp = '{e0, e1, e2, e3};
    cmp({name, "_size"}, 32'(dut_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      cmp(name, (i < dut_log.size()) ? 32'(dut_log[i]) : 32'hDEAD, 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b0;
    fq.deq_ready = 1'b0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_req", 32'(fq.imem_req), 32'd0);
    cmp("rst_dv", 32'(fq.deq_valid), 32'd0);
    cmp("rst_count", 32'(fq.count), 32'd0);
    cmp("rst_addr", 32'(fq.imem_addr), 32'h0);

    // Reset release with deq_ready=1
    @(posedge clk); #1;
    reset = 1'b1;
    fq.deq_ready = 1'b1;
    @(negedge clk);
    cmp("c0_addr", 32'(fq.imem_addr), 32'h0);
    cmp("c0_req", 32'(fq.imem_req), 32'd1);
    cmp("c0_dv", 32'(fq.deq_valid), 32'd0);
    @(negedge clk);
    cmp("c1_addr", 32'(fq.imem_addr), 32'h4);
    cmp("c1_dv", 32'(fq.deq_valid), 32'(BYP));
    if (BYP) cmp("c1_pc", 32'(fq.deq_pc), 32'h0);
    @(negedge clk);
    cmp("c2_addr", 32'(fq.imem_addr), 32'h8);
    cmp("c2_dv", 32'(fq.deq_valid), 32'd1);
    cmp("c2_pc", 32'(fq.deq_pc), BYP ? 32'h4 : 32'h0);
    cmp("c2_instr", 32'(fq.deq_instr), BYP ? 32'h1 : 32'h0);
    repeat (8) begin
      @(negedge clk);
      cmp("steady_count", 32'(fq.count), BYP ? 32'd0 : 32'd1);
    end

    // Fill with deq_ready=0, then drain
    reset_pulse(1'b0);
    repeat (8) @(negedge clk);
    cmp("full_count", 32'(fq.count), 32'd4);
    cmp("full_req", 32'(fq.imem_req), 32'd0);
    cmp("full_addr", 32'(fq.imem_addr), 32'h10);
    cmp("full_head", 32'(fq.deq_pc), 32'h0);
    @(posedge clk); #1;
    dut_log.delete();
    fq.deq_ready = 1'b1;
    repeat (8) @(posedge clk);
    check_log("drain", 16'h0, 16'h4, 16'h8, 16'hC);
    cmp("drain_refetch", 32'(dut_log.size() > 4 ? dut_log[4] : 16'hDEAD), 32'h10);

    // Redirect with 3 queued and one in flight
    reset_pulse(1'b0);
    wait_count(2, "pre_redirect_count");
    @(posedge clk); #1;
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 16'h0103;
    @(negedge clk);
    cmp("t_count", 32'(fq.count), 32'd3);
    cmp("t_req", 32'(fq.imem_req), 32'd0);
    @(posedge clk); #1;
    fq.redirect_valid = 1'b0;
    @(negedge clk);
    cmp("t1_count", 32'(fq.count), 32'd0);
    cmp("t1_dv", 32'(fq.deq_valid), 32'd0);
    cmp("t1_addr", 32'(fq.imem_addr), 32'h0100);
    cmp("t1_req", 32'(fq.imem_req), 32'd1);
    @(negedge clk);
    cmp("t2_dv", 32'(fq.deq_valid), 32'(BYP));
    @(negedge clk);
    cmp("t3_dv", 32'(fq.deq_valid), 32'd1);
    cmp("t3_pc", 32'(fq.deq_pc), 32'h0100);

    // Redirect near the top of the address space
    @(posedge clk); #1;
    fq.deq_ready = 1'b1;
    fq.redirect_valid = 1'b1;
    fq.redirect_pc = 16'hFFF8;
    @(posedge clk); #1;
    fq.redirect_valid = 1'b0;
    dut_log.delete();
    repeat (8) @(posedge clk);
    check_log("wrap", 16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004);

    // Asynchronous reset mid-stream with count=3
    reset_pulse(1'b0);
    wait_count(3, "pre_reset_count");
    #2;
    reset = 1'b0;
    #1;
    cmp("arst_dv", 32'(fq.deq_valid), 32'd0);
    cmp("arst_count", 32'(fq.count), 32'd0);
    cmp("arst_req", 32'(fq.imem_req), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    fq.deq_ready = 1'b1;
    dut_log.delete();
    @(negedge clk);
    cmp("arst_restart_addr", 32'(fq.imem_addr), 32'(RESET_PC));
    repeat (6) @(posedge clk);
    check_log("arst_restart", 16'h0, 16'h4, 16'h8, 16'hC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      fq.deq_ready      = ($urandom_range(0, 9) < 7);
      fq.redirect_valid = ($urandom_range(0, 19) == 0);
      fq.redirect_pc    = 16'($urandom);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 3));
        reset = 1'b0;
      end
    end
    @(posedge clk); #1;
    fq.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
